// File: rtl/instr_mem_rd_arbiter.sv
// instr_mem_rd_arbiter: round-robin arbiter sharing one AXI4 AR/R read port among NUM_REQ instruction-cache controllers
// Ports:
//   i_clk, i_areset_n           clock, asynchronous active-low reset
//   o_grant, o_busy             one-hot current owner, FSM not idle
//   i_ar_* / o_ar_ready         per-requester AR channels (flattened, indexed by requester)
//   o_r_valid / i_r_ready       per-requester R handshake
//   o_r_data/resp/last          R payload broadcast to all requesters
//   o_ar_* / i_ar_ready         memory-side AR channel
//   i_r_* / o_r_ready           memory-side R channel
module instr_mem_rd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32
) (
    input  logic                           i_clk,
    input  logic                           i_areset_n,
    output logic [NUM_REQ-1:0]             o_grant,
    output logic                           o_busy,
    input  logic [NUM_REQ-1:0]             i_ar_valid,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   i_ar_addr,
    input  logic [NUM_REQ*8-1:0]           i_ar_len,
    input  logic [NUM_REQ*3-1:0]           i_ar_size,
    input  logic [NUM_REQ*2-1:0]           i_ar_burst,
    output logic [NUM_REQ-1:0]             o_ar_ready,
    output logic [NUM_REQ-1:0]             o_r_valid,
    input  logic [NUM_REQ-1:0]             i_r_ready,
    output logic [DATA_SIZE-1:0]           o_r_data,
    output logic [1:0]                     o_r_resp,
    output logic                           o_r_last,
    output logic                           o_ar_valid,
    output logic [ADDR_SIZE-1:0]           o_ar_addr,
    output logic [7:0]                     o_ar_len,
    output logic [2:0]                     o_ar_size,
    output logic [1:0]                     o_ar_burst,
    input  logic                           i_ar_ready,
    input  logic                           i_r_valid,
    input  logic [DATA_SIZE-1:0]           i_r_data,
    input  logic [1:0]                     i_r_resp,
    input  logic                           i_r_last,
    output logic                           o_r_ready
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW:0] NQ = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ-1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t state, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d, rot;
    logic [IW-1:0] g, g_d, ptr, ptr_d, off, pick, g_nxt;
    logic [IW:0] sum;
    logic in_addr, in_data;
    logic [ADDR_SIZE-1:0] addr_a [NUM_REQ];
    logic [7:0] len_a [NUM_REQ];
    logic [2:0] size_a [NUM_REQ];
    logic [1:0] burst_a [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign addr_a[k]  = i_ar_addr[k*ADDR_SIZE +: ADDR_SIZE];
        assign len_a[k]   = i_ar_len[k*8 +: 8];
        assign size_a[k]  = i_ar_size[k*3 +: 3];
        assign burst_a[k] = i_ar_burst[k*2 +: 2];
    end

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit
    // of the rotated vector is the offset of the next winner from ptr.
    always_comb begin
        rot = NUM_REQ'({i_ar_valid, i_ar_valid} >> ptr);
        off = '0;
        for (int i = NUM_REQ-1; i >= 0; i--)
            if (rot[i]) off = IW'(i);
        sum  = {1'b0, ptr} + {1'b0, off};
        pick = sum >= NQ ? IW'(sum - NQ) : IW'(sum);
    end

    assign g_nxt   = (g == LAST_IDX) ? '0 : g + 1'b1;
    assign in_addr = state == ADDR;
    assign in_data = state == DATA;

    assign o_ar_valid = in_addr & i_ar_valid[g];
    assign o_ar_addr  = in_addr ? addr_a[g]  : '0;
    assign o_ar_len   = in_addr ? len_a[g]   : '0;
    assign o_ar_size  = in_addr ? size_a[g]  : '0;
    assign o_ar_burst = in_addr ? burst_a[g] : '0;
    assign o_ar_ready = in_addr ? grant_q & {NUM_REQ{i_ar_ready}} : '0;
    assign o_r_valid  = in_data ? grant_q & {NUM_REQ{i_r_valid}} : '0;
    assign o_r_ready  = in_data & i_r_ready[g];
    assign o_r_data   = i_r_data;
    assign o_r_resp   = i_r_resp;
    assign o_r_last   = i_r_last;
    assign o_grant    = grant_q;
    assign o_busy     = state != IDLE;

    always_comb begin
        state_d = state;
        grant_d = grant_q;
        g_d     = g;
        ptr_d   = ptr;
        case (state)
            IDLE: if (|i_ar_valid) begin
                state_d = ADDR;
                g_d     = pick;
                grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
            end
            ADDR: if (o_ar_valid && i_ar_ready) begin
                state_d = DATA;
            end else if (!i_ar_valid[g]) begin
                // requester withdrew before the handshake: abandon and rotate
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = g_nxt;
            end
            DATA: if (i_r_valid && o_r_ready && i_r_last) begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = g_nxt;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            state   <= IDLE;
            grant_q <= '0;
            g       <= '0;
            ptr     <= '0;
        end else begin
            state   <= state_d;
            grant_q <= grant_d;
            g       <= g_d;
            ptr     <= ptr_d;
        end
    end
endmodule

// File: tb/tb_instr_mem_rd_arbiter.sv
// tb_instr_mem_rd_arbiter: table-driven bench with an R-beat scoreboard for instr_mem_rd_arbiter
module tb_instr_mem_rd_arbiter;
    logic        i_clk, i_areset_n;
    logic [3:0]  o_grant;
    logic        o_busy;
    logic [3:0]  i_ar_valid;
    logic [127:0] i_ar_addr;
    logic [31:0] i_ar_len;
    logic [11:0] i_ar_size;
    logic [7:0]  i_ar_burst;
    logic [3:0]  o_ar_ready, o_r_valid, i_r_ready;
    logic [31:0] o_r_data;
    logic [1:0]  o_r_resp;
    logic        o_r_last;
    logic        o_ar_valid;
    logic [31:0] o_ar_addr;
    logic [7:0]  o_ar_len;
    logic [2:0]  o_ar_size;
    logic [1:0]  o_ar_burst;
    logic        i_ar_ready, i_r_valid;
    logic [31:0] i_r_data;
    logic [1:0]  i_r_resp;
    logic        i_r_last, o_r_ready;

    instr_mem_rd_arbiter #(.NUM_REQ(4), .ADDR_SIZE(32), .DATA_SIZE(32)) dut (
        .i_clk(i_clk), .i_areset_n(i_areset_n), .o_grant(o_grant), .o_busy(o_busy),
        .i_ar_valid(i_ar_valid), .i_ar_addr(i_ar_addr), .i_ar_len(i_ar_len),
        .i_ar_size(i_ar_size), .i_ar_burst(i_ar_burst), .o_ar_ready(o_ar_ready),
        .o_r_valid(o_r_valid), .i_r_ready(i_r_ready), .o_r_data(o_r_data),
        .o_r_resp(o_r_resp), .o_r_last(o_r_last), .o_ar_valid(o_ar_valid),
        .o_ar_addr(o_ar_addr), .o_ar_len(o_ar_len), .o_ar_size(o_ar_size),
        .o_ar_burst(o_ar_burst), .i_ar_ready(i_ar_ready), .i_r_valid(i_r_valid),
        .i_r_data(i_r_data), .i_r_resp(i_r_resp), .i_r_last(i_r_last), .o_r_ready(o_r_ready)
    );

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  late;
        logic [31:0] addr;
        logic [7:0]  len;
        int          ar_wait;
        int          r_stall;
        int          rst_beat;
        int          exp;
    } vec_t;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    vec_t  tbl [15];
    beat_t exp_q [$];
    int    total = 0;
    int    bad = 0;

    initial i_clk = 0;
    always #5 i_clk = ~i_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic set_fields(input vec_t v);
        for (int k = 0; k < 4; k++) begin
            i_ar_addr[k*32 +: 32] = (k == v.exp) ? v.addr : ~v.addr ^ 32'(k);
            i_ar_len[k*8 +: 8]    = (k == v.exp) ? v.len : 8'hF0 | 8'(k);
            i_ar_size[k*3 +: 3]   = (k == v.exp) ? 3'd2 : 3'd7;
            i_ar_burst[k*2 +: 2]  = (k == v.exp) ? 2'd1 : 2'd3;
        end
    endtask

    task automatic run_burst(input vec_t v);
        logic [3:0] oh;
        beat_t e;
        oh = 4'b1 << v.exp;
        set_fields(v);
        i_ar_valid = v.mask;
        i_ar_ready = v.ar_wait < 0;
        #1 chk("idle_no_ar", {63'b0, o_ar_valid}, 0);
        chk("idle_ar_ready", {60'b0, o_ar_ready}, 0);
        chk("idle_busy", {63'b0, o_busy}, 0);
        @(negedge i_clk);
        chk("grant", {60'b0, o_grant}, {60'b0, oh});
        chk("busy", {63'b0, o_busy}, 1);
        chk("ar_valid", {63'b0, o_ar_valid}, 1);
        chk("ar_addr", {32'b0, o_ar_addr}, {32'b0, v.addr});
        chk("ar_len", {56'b0, o_ar_len}, {56'b0, v.len});
        chk("ar_size", {61'b0, o_ar_size}, 2);
        chk("ar_burst", {62'b0, o_ar_burst}, 1);
        repeat (v.ar_wait > 0 ? v.ar_wait : 0) begin
            chk("ar_hold_ready", {60'b0, o_ar_ready}, 0);
            chk("ar_hold_valid", {63'b0, o_ar_valid}, 1);
            chk("ar_hold_addr", {32'b0, o_ar_addr}, {32'b0, v.addr});
            @(negedge i_clk);
        end
        i_ar_ready = 1;
        #1 chk("ar_ready", {60'b0, o_ar_ready}, {60'b0, oh});
        for (int b = 0; b <= int'(v.len); b++)
            exp_q.push_back('{d: {v.addr[15:0], 8'hA5, 8'(b)}, r: 2'(b), l: b == int'(v.len)});
        @(negedge i_clk);
        i_ar_ready = 0;
        i_ar_valid[v.exp] = 1'b0;
        #1 chk("data_no_ar", {63'b0, o_ar_valid}, 0);
        chk("data_ar_addr", {32'b0, o_ar_addr}, 0);
        for (int b = 0; b <= int'(v.len); b++) begin
            i_r_valid = 1;
            i_r_data  = {v.addr[15:0], 8'hA5, 8'(b)};
            i_r_resp  = 2'(b);
            i_r_last  = b == int'(v.len);
            if (i_r_last) i_ar_valid = i_ar_valid | v.late;
            if (b == v.rst_beat) begin
                i_r_ready = oh;
                #1 i_areset_n = 0;
                #1 chk("rst_grant", {60'b0, o_grant}, 0);
                chk("rst_busy", {63'b0, o_busy}, 0);
                chk("rst_r_valid", {60'b0, o_r_valid}, 0);
                chk("rst_r_ready", {63'b0, o_r_ready}, 0);
                chk("rst_ar_valid", {63'b0, o_ar_valid}, 0);
                chk("rst_ar_ready", {60'b0, o_ar_ready}, 0);
                i_r_valid = 0;
                i_r_last = 0;
                i_r_ready = 0;
                i_ar_valid = 0;
                exp_q.delete();
                @(negedge i_clk);
                i_areset_n = 1;
                #1 chk("post_rst_busy", {63'b0, o_busy}, 0);
                return;
            end
            if (b == 1) repeat (v.r_stall) begin
                i_r_ready = ~oh;
                #1 chk("stall_r_ready", {63'b0, o_r_ready}, 0);
                chk("stall_r_valid", {60'b0, o_r_valid}, {60'b0, oh});
                @(negedge i_clk);
            end
            i_r_ready = oh;
            #1 chk("r_ready", {63'b0, o_r_ready}, 1);
            chk("r_valid", {60'b0, o_r_valid}, {60'b0, oh});
            if (o_r_valid[v.exp] && i_r_ready[v.exp]) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("r_data", {32'b0, o_r_data}, {32'b0, e.d});
                    chk("r_resp", {62'b0, o_r_resp}, {62'b0, e.r});
                    chk("r_last", {63'b0, o_r_last}, {63'b0, e.l});
                end
            end
            @(negedge i_clk);
        end
        i_r_valid = 0;
        i_r_last = 0;
        i_r_ready = 0;
        #1 chk("end_busy", {63'b0, o_busy}, 0);
        chk("end_grant", {60'b0, o_grant}, 0);
        chk("sb_empty", 64'(exp_q.size()), 0);
    endtask

    initial begin
        vec_t v;
        //            mask     late     addr          len wait stall rst exp
        tbl[0]  = '{4'b1111, 4'b0000, 32'h0000_2000, 8'd1, 0, 0, -1, 0};
        tbl[1]  = '{4'b1111, 4'b0000, 32'h0000_3100, 8'd0, 5, 0, -1, 1};
        tbl[2]  = '{4'b1111, 4'b0000, 32'h0000_4200, 8'd3, 0, 3, -1, 2};
        tbl[3]  = '{4'b1111, 4'b0000, 32'h0000_5300, 8'd2, 0, 0, -1, 3};
        tbl[4]  = '{4'b1111, 4'b0000, 32'h0000_6000, 8'd1, 0, 0, -1, 0};
        tbl[5]  = '{4'b0100, 4'b0000, 32'h0000_1040, 8'd3, -1, 0, -1, 2};
        tbl[6]  = '{4'b0010, 4'b0000, 32'h0000_7100, 8'd0, 0, 0, -1, 1};
        tbl[7]  = '{4'b1001, 4'b0000, 32'h0000_8300, 8'd2, 0, 0, -1, 3};
        tbl[8]  = '{4'b1001, 4'b0000, 32'h0000_9000, 8'd1, 0, 0, -1, 0};
        tbl[9]  = '{4'b0001, 4'b0010, 32'h0000_A000, 8'd2, 0, 0, -1, 0};
        tbl[10] = '{4'b0010, 4'b0000, 32'h0000_B100, 8'd0, 0, 0, -1, 1};
        tbl[11] = '{4'b0100, 4'b0000, 32'h0000_C200, 8'd3, 0, 0, 1, 2};
        tbl[12] = '{4'b0101, 4'b0000, 32'h0000_D000, 8'd1, 0, 0, -1, 0};
        tbl[13] = '{4'b1000, 4'b0000, 32'h0000_E300, 8'd2, 0, 0, -1, 3};
        tbl[14] = '{4'b1011, 4'b0000, 32'h0000_F300, 8'd1, 0, 0, -1, 3};
        i_areset_n = 0;
        i_ar_valid = 0;
        i_ar_addr = 0;
        i_ar_len = 0;
        i_ar_size = 0;
        i_ar_burst = 0;
        i_r_ready = 0;
        i_ar_ready = 0;
        i_r_valid = 0;
        i_r_data = 0;
        i_r_resp = 0;
        i_r_last = 0;
        repeat (2) @(negedge i_clk);
        chk("reset_grant", {60'b0, o_grant}, 0);
        chk("reset_busy", {63'b0, o_busy}, 0);
        chk("reset_ar_valid", {63'b0, o_ar_valid}, 0);
        chk("reset_ar_ready", {60'b0, o_ar_ready}, 0);
        chk("reset_r_valid", {60'b0, o_r_valid}, 0);
        chk("reset_r_ready", {63'b0, o_r_ready}, 0);
        chk("reset_ar_addr", {32'b0, o_ar_addr}, 0);
        i_areset_n = 1;
        for (int i = 0; i < 14; i++) run_burst(tbl[i]);
        // requester 1 withdraws its AR before the handshake; ptr must move to 2
        v = '{4'b0010, 4'b0000, 32'h0000_1100, 8'd0, 0, 0, -1, 1};
        set_fields(v);
        i_ar_valid = v.mask;
        @(negedge i_clk);
        chk("abort_grant", {60'b0, o_grant}, 4'b0010);
        chk("abort_ar_valid", {63'b0, o_ar_valid}, 1);
        i_ar_valid = 0;
        #1 chk("abort_drop_valid", {63'b0, o_ar_valid}, 0);
        @(negedge i_clk);
        chk("abort_busy", {63'b0, o_busy}, 0);
        chk("abort_grant_clr", {60'b0, o_grant}, 0);
        run_burst(tbl[14]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_mem_rd_arbiter.md
# instr_mem_rd_arbiter

Round-robin arbiter that shares one AXI4 read port (AR + R channels) to instruction memory among `NUM_REQ` per-core instruction-cache controllers. Each cache controller presents a burst read on a miss; the arbiter grants one requester at a time and holds the grant for the whole burst, up to and including the beat with `last`. It then rotates priority to the next requester. It sits between the per-core cache controllers and the shared memory-side AXI master port of the multicore top level. Only AR/R are handled; write channels are out of scope.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting cache controllers; must be ≥ 2.
- `ADDR_SIZE`, 32: AXI address width.
- `DATA_SIZE`, 32: AXI read data width (equal to `INST_SIZE`).

Ports (`N` = `NUM_REQ`; requester-side vectors are indexed by requester):

Clock, reset and status:
- `i_clk`  in  1  system clock.
- `i_areset_n`  in  1  asynchronous, active-low reset.
- `o_grant`  out  N  one-hot owner of the memory port; all zeros when idle.
- `o_busy`  out  1  high whenever the state is not IDLE.

Requester side:
- `i_ar_valid`  in  N  per-requester AR valid.
- `i_ar_addr`  in  N×ADDR_SIZE  per-requester AR address.
- `i_ar_len`  in  N×8  per-requester AR length.
- `i_ar_size`  in  N×3  per-requester AR size.
- `i_ar_burst`  in  N×2  per-requester AR burst type.
- `o_ar_ready`  out  N  per-requester AR ready.
- `o_r_valid`  out  N  per-requester R valid.
- `i_r_ready`  in  N  per-requester R ready.
- `o_r_data`  out  DATA_SIZE  R data, broadcast to all requesters.
- `o_r_resp`  out  2  R response, broadcast.
- `o_r_last`  out  1  R last, broadcast.

Memory side:
- `o_ar_valid`, `o_ar_addr`, `o_ar_len`, `o_ar_size`, `o_ar_burst`  out  widths as above  AR channel to memory.
- `i_ar_ready`  in  1  memory AR ready.
- `i_r_valid`, `i_r_data`, `i_r_resp`, `i_r_last`  in  widths as above  R channel from memory.
- `o_r_ready`  out  1  R ready to memory.

## Operation
- FSM states are IDLE, ADDR and DATA. Reset state is IDLE, with `grant_q` = 0 and round-robin pointer `ptr` = 0.
- **IDLE:**
  - If `|i_ar_valid`, pick the first set bit searching `ptr`, `ptr+1`, … modulo N.
  - Register that requester as one-hot `grant_q` and go to ADDR.
  - No AR is driven to memory in IDLE.
- **ADDR:**
  - Memory AR fields are a mux of the granted requester's fields.
  - `o_ar_valid = i_ar_valid[g]` and `o_ar_ready[g] = i_ar_ready`, where g is the granted index.
  - On `o_ar_valid & i_ar_ready`, go to DATA.
  - If `i_ar_valid[g]` drops before the handshake (protocol violation), go to IDLE, set `ptr = g+1`, and clear the grant.
- **DATA:**
  - `o_r_valid[g] = i_r_valid`; `o_r_ready = i_r_ready[g]`; data, resp and last are passed through combinationally.
  - On `i_r_valid & o_r_ready & i_r_last`, go to IDLE and set `ptr = (g+1) mod N`.
  - `grant_q` clears in the same cycle as that transition.
- Exactly one burst is outstanding at a time. The burst length is whatever `i_ar_len` carried; the arbiter does not count beats, it relies on `last`.
- All `o_ar_ready` and `o_r_valid` bits of non-granted requesters are 0 in every state. `o_r_ready` is 0 outside DATA.
- `r.resp` errors are forwarded unchanged; the arbiter does not act on them.
- `o_grant = grant_q`; `o_busy = (state != IDLE)`.

## Timing
- Reset values:
  - `o_ar_valid`, `o_ar_ready`, `o_r_valid`, `o_r_ready`, `o_grant` and `o_busy` are all 0.
  - AR fields are driven 0 while not in ADDR.
  - `o_r_data`, `o_r_resp` and `o_r_last` are pass-through at all times; they are don't-care unless the corresponding valid is set.
- Arbitration latency:
  - A request seen in IDLE in cycle t gives `o_ar_valid` = 1 in cycle t+1.
  - With `i_ar_ready` already high, `o_ar_ready[g]` pulses in t+1 and the state is DATA in t+2.
- End-of-burst turnaround:
  - The last beat accepted in cycle t puts the FSM in IDLE at t+1.
  - A pending request is granted at t+1 and issued on AR at t+2.
  - Minimum gap between consecutive AR issues is therefore 2 cycles after `last`.
- R path: zero-cycle combinational pass-through; no buffering, so backpressure from `i_r_ready[g]` reaches memory in the same cycle.
- Simultaneous events:
  - Requests arriving while busy wait; requesters hold `i_ar_valid` stable.
  - A new request at the same edge as `last` is evaluated in the following IDLE cycle with the updated `ptr`.
- Reset mid-burst returns to IDLE immediately and clears the grant. The memory side must be reset by the same `i_areset_n`.
- Starvation bound: a requester holding `i_ar_valid` waits at most N−1 bursts.

## Test plan
- **Single request:** requester 2 requests addr 0x0000_1040, len 3, `i_ar_ready` = 1 → `o_grant` = 4'b0100 the next cycle; `o_ar_addr` = 0x1040, `o_ar_len` = 3. Four R beats with last on the 4th reach only `o_r_valid[2]`. The FSM is IDLE one cycle after last.
- **Round-robin rotation:** all four requesters hold requests continuously with `ptr` = 0 → grant order is 0, 1, 2, 3, 0. Each grant lasts until its own last beat; no grant overlaps another.
- **Pointer skip:** after requester 1 completes, only requesters 0 and 3 request → requester 3 is granted first, then 0.
- **Backpressure:** memory holds `i_ar_ready` = 0 for 5 cycles → `o_ar_valid` stays 1 with a stable address, and `o_ar_ready[g]` stays 0 until the handshake. During DATA, `i_r_ready[g]` = 0 for 3 cycles forces `o_r_ready` = 0, and no beat is lost.
- **Simultaneous last and new request:** requester 1 asserts valid in the same cycle as requester 0's last beat → grant moves to 1 one cycle later, and AR issues two cycles after last.
- **Reset mid-burst:** `i_areset_n` is asserted low during beat 2 of a 4-beat burst → all outputs are 0 asynchronously. After release, the FSM is IDLE with `ptr` = 0, and a new request from requester 3 is granted normally.
